// File: rtl/ss_stream_host.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ss_stream_host : buffers W/X elements, replays them as one burst into the
// systolic core, then forwards the indexed result burst.  Rev 1.0
// ---------------------------------------------------------------------------
module ss_stream_host #(
  parameter int DATA_W  = 16,
  parameter int RES_W   = 40,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic              cmd_size,
  output logic              cmd_ready,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              in_valid,
  output logic [DATA_W-1:0] matrix,
  output logic              matrix_size,
  input  logic              out_valid,
  input  logic [RES_W-1:0]  out_value,
  output logic              res_valid,
  output logic [RES_W-1:0]  res_data,
  output logic [3:0]        res_idx,
  output logic              res_last,
  output logic              done,
  output logic [1:0]        status
);

  localparam int                c_TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_LOAD = 3'd1;
  localparam logic [2:0] c_SEND = 3'd2;
  localparam logic [2:0] c_WAIT = 3'd3;
  localparam logic [2:0] c_RECV = 3'd4;
  localparam logic [2:0] c_DONE = 3'd5;

  logic [2:0]         state_q, state_d;
  logic               size_q;
  logic [4:0]         cnt_q;
  logic [3:0]         idx_q;
  logic [c_TMO_W-1:0] tmo_q;
  logic [DATA_W-1:0]  mem_q [32];

  logic               in_valid_q, matrix_size_q;
  logic [DATA_W-1:0]  matrix_q;
  logic               res_valid_q, res_last_q;
  logic [RES_W-1:0]   res_data_q;
  logic [3:0]         res_idx_q;
  logic [1:0]         status_q;

  logic [4:0]         w_cnt_last;
  logic [3:0]         w_idx_last;
  logic               w_cmd_hs, w_ld_hs, w_res_hs;

  assign w_cnt_last = size_q ? 5'd31 : 5'd7;
  assign w_idx_last = size_q ? 4'd15 : 4'd3;
  assign w_cmd_hs   = (state_q == c_IDLE) && cmd_valid;
  assign w_ld_hs    = (state_q == c_LOAD) && s_valid;
  assign w_res_hs   = ((state_q == c_WAIT) || (state_q == c_RECV)) && out_valid;

  always_ff @(posedge clk) begin
    if (rst) state_q <= c_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: if (cmd_valid) state_d = c_LOAD;
      c_LOAD: if (s_valid && (cnt_q == w_cnt_last)) state_d = c_SEND;
      c_SEND: if (cnt_q == w_cnt_last) state_d = c_WAIT;
      c_WAIT: begin
        if (out_valid)                state_d = c_RECV;
        else if (tmo_q == c_TMO_LAST) state_d = c_DONE;
      end
      c_RECV: if (!out_valid || (idx_q == w_idx_last)) state_d = c_DONE;
      c_DONE: state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == c_IDLE);
    s_ready   = (state_q == c_LOAD);
    done      = (state_q == c_DONE);
  end

  always_ff @(posedge clk) begin
    if (w_ld_hs) mem_q[cnt_q] <= s_data;
  end

  // cnt_q is the write pointer in LOAD and the index currently on the bus in SEND
  always_ff @(posedge clk) begin
    if (rst) begin
      size_q        <= 1'b0;
      cnt_q         <= 5'd0;
      idx_q         <= 4'd0;
      tmo_q         <= '0;
      in_valid_q    <= 1'b0;
      matrix_q      <= '0;
      matrix_size_q <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_idx_q     <= 4'd0;
      res_last_q    <= 1'b0;
      status_q      <= 2'b00;
    end else begin
      in_valid_q    <= 1'b0;
      matrix_q      <= '0;
      matrix_size_q <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_idx_q     <= 4'd0;
      res_last_q    <= 1'b0;

      if (w_cmd_hs) begin
        size_q   <= cmd_size;
        cnt_q    <= 5'd0;
        status_q <= 2'b00;
      end

      if (w_ld_hs) begin
        if (cnt_q == w_cnt_last) begin
          cnt_q         <= 5'd0;
          in_valid_q    <= 1'b1;
          matrix_q      <= mem_q[0];
          matrix_size_q <= size_q;
        end else begin
          cnt_q <= cnt_q + 5'd1;
        end
      end

      if ((state_q == c_SEND) && (cnt_q != w_cnt_last)) begin
        cnt_q         <= cnt_q + 5'd1;
        in_valid_q    <= 1'b1;
        matrix_q      <= mem_q[cnt_q + 5'd1];
        matrix_size_q <= size_q;
      end

      if (state_q == c_WAIT) tmo_q <= tmo_q + 1'b1;
      else                   tmo_q <= '0;

      if (w_res_hs) begin
        res_valid_q <= 1'b1;
        res_data_q  <= out_value;
        res_idx_q   <= idx_q;
        res_last_q  <= (idx_q == w_idx_last);
        if (idx_q != w_idx_last) idx_q <= idx_q + 4'd1;
      end else if ((state_q != c_WAIT) && (state_q != c_RECV)) begin
        idx_q <= 4'd0;
      end

      if ((state_q == c_WAIT) && !out_valid && (tmo_q == c_TMO_LAST)) status_q <= 2'b01;
      if ((state_q == c_RECV) && !out_valid)                           status_q <= 2'b10;
    end
  end

  assign in_valid    = in_valid_q;
  assign matrix      = matrix_q;
  assign matrix_size = matrix_size_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_idx     = res_idx_q;
  assign res_last    = res_last_q;
  assign status      = status_q;

endmodule
`default_nettype wire
